inimigo_colisao: RTL and testbench



---
 rtl/inimigo_colisao_pkg.sv | 22 ++
 rtl/inimigo_colisao_caixa_sobreposicao.sv | 34 +++
 rtl/inimigo_colisao.sv | 117 +++++++++++
 tb/tb_inimigo_colisao.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inimigo_colisao_pkg.sv
// Shared game definitions for the enemy collision block: coordinate width, FSM
// encoding, counter widths and the saturating score adder.
package inimigo_colisao_pkg;

    localparam int COORD_W = 10;
    localparam int TIMER_W = 25;
    localparam int PISCA_W = 22;

    typedef enum logic [1:0] {
        ATIVO     = 2'd0,
        INVULN    = 2'd1,
        DESTRUIDO = 2'd2
    } estado_t;

    // Score must stick at the top instead of wrapping back to a small value.
    function automatic logic [15:0] soma_sat(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/inimigo_colisao_caixa_sobreposicao.sv
// Generic axis-aligned box overlap with half-open intervals; also used by the
// player collision path.
module caixa_sobreposicao
    import inimigo_colisao_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] a_larg,
    input  logic [COORD_W-1:0] a_alt,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] b_larg,
    input  logic [COORD_W-1:0] b_alt,
    output logic               sobrep
);

    // One extra bit so a box touching the right/bottom of the coordinate range
    // cannot wrap its far edge back to zero.
    logic [COORD_W:0] a_dir, a_baixo, b_dir, b_baixo;
    logic             vazia;

    assign a_dir   = {1'b0, a_x} + {1'b0, a_larg};
    assign a_baixo = {1'b0, a_y} + {1'b0, a_alt};
    assign b_dir   = {1'b0, b_x} + {1'b0, b_larg};
    assign b_baixo = {1'b0, b_y} + {1'b0, b_alt};

    // Without this, an empty box could still satisfy both interval tests.
    assign vazia = (a_larg == '0) || (a_alt == '0) || (b_larg == '0) || (b_alt == '0);

    assign sobrep = !vazia
                 && ({1'b0, b_x} < a_dir)   && (b_dir   > {1'b0, a_x})
                 && ({1'b0, b_y} < a_baixo) && (b_baixo > {1'b0, a_y});

endmodule

// File: rtl/inimigo_colisao.sv
// Enemy life cycle: shot-vs-enemy test (registered), damage FSM with
// invulnerability blink, shot acknowledge and score accumulation.
module inimigo_colisao
    import inimigo_colisao_pkg::*;
#(
    parameter int          VIDAS         = 3,
    parameter int          TIRO_L        = 2,
    parameter int          TIRO_A        = 6,
    parameter int          INVULN_CICLOS = 25_000_000,
    parameter int          PISCA_DIV     = 2_500_000,
    parameter logic [15:0] PONTOS_ACERTO = 16'd10
) (
    input  logic               CLOCK_50,
    input  logic               resetInimigo,
    input  logic               pausa,
    input  logic [COORD_W-1:0] inim_x,
    input  logic [COORD_W-1:0] inim_y,
    input  logic [COORD_W-1:0] inim_larg,
    input  logic [COORD_W-1:0] inim_alt,
    input  logic               tiro_valido,
    input  logic [COORD_W-1:0] tiro_x,
    input  logic [COORD_W-1:0] tiro_y,
    output logic               tiro_consumido,
    output logic               acerto,
    output logic [2:0]         vidas,
    output logic               inimigo_visivel,
    output logic               destruido,
    output logic [15:0]        pontos
);

    localparam logic [TIMER_W-1:0] TIMER_INI = TIMER_W'(INVULN_CICLOS - 1);
    localparam logic [PISCA_W-1:0] PISCA_INI = PISCA_W'(PISCA_DIV - 1);

    estado_t            estado;
    logic               sobrep_comb;
    logic               sobrep;
    logic [TIMER_W-1:0] timer;
    logic [PISCA_W-1:0] pisca;

    caixa_sobreposicao u_caixa (
        .a_x    (inim_x),
        .a_y    (inim_y),
        .a_larg (inim_larg),
        .a_alt  (inim_alt),
        .b_x    (tiro_x),
        .b_y    (tiro_y),
        .b_larg (COORD_W'(TIRO_L)),
        .b_alt  (COORD_W'(TIRO_A)),
        .sobrep (sobrep_comb)
    );

    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            estado          <= ATIVO;
            vidas           <= 3'(VIDAS);
            inimigo_visivel <= 1'b1;
            destruido       <= 1'b0;
            acerto          <= 1'b0;
            tiro_consumido  <= 1'b0;
            pontos          <= '0;
            timer           <= '0;
            pisca           <= '0;
            sobrep          <= 1'b0;
        end else begin
            // A paused cycle drops whatever the overlap test found.
            sobrep <= tiro_valido & sobrep_comb & ~pausa;

            // NOTE: pulses default low here and are overridden below; the last
            // non-blocking assignment in the block wins, giving one-cycle strobes.
            tiro_consumido <= 1'b0;
            acerto         <= 1'b0;

            if (!pausa) begin
                unique case (estado)
                    ATIVO: begin
                        // tiro_consumido still high means this is the shot just acked.
                        if (sobrep && tiro_valido && !tiro_consumido) begin
                            tiro_consumido <= 1'b1;
                            acerto         <= 1'b1;
                            vidas          <= vidas - 3'd1;
                            pontos         <= soma_sat(pontos, PONTOS_ACERTO);
                            if (vidas == 3'd1) begin
                                estado          <= DESTRUIDO;
                                inimigo_visivel <= 1'b0;
                                destruido       <= 1'b1;
                            end else begin
                                estado <= INVULN;
                                timer  <= TIMER_INI;
                                pisca  <= PISCA_INI;
                            end
                        end
                    end
                    INVULN: begin
                        if (timer == '0) begin
                            estado          <= ATIVO;
                            inimigo_visivel <= 1'b1;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                            if (pisca == '0) begin
                                inimigo_visivel <= ~inimigo_visivel;
                                pisca           <= PISCA_INI;
                            end else begin
                                pisca <= pisca - PISCA_W'(1);
                            end
                        end
                    end
                    DESTRUIDO: begin
                        inimigo_visivel <= 1'b0;
                        destruido       <= 1'b1;
                    end
                    default: estado <= ATIVO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inimigo_colisao.sv
// Directed bench for inimigo_colisao: overlap vector table plus hand-written
// sequences for latency, invulnerability blink, death, pause and reset.
module tb_inimigo_colisao;

    localparam int          T_INV = 20;
    localparam int          P_DIV = 4;
    localparam logic [15:0] PTS   = 16'd10;

    logic       CLOCK_50 = 1'b0;
    logic       resetInimigo;
    logic       pausa;
    logic [9:0] inim_x, inim_y, inim_larg, inim_alt;
    logic       tiro_valido;
    logic [9:0] tiro_x, tiro_y;
    logic       tiro_consumido, acerto, inimigo_visivel, destruido;
    logic [2:0] vidas;
    logic [15:0] pontos;

    int n_cmp = 0;
    int n_err = 0;

    inimigo_colisao #(
        .VIDAS(3), .TIRO_L(2), .TIRO_A(6),
        .INVULN_CICLOS(T_INV), .PISCA_DIV(P_DIV), .PONTOS_ACERTO(PTS)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .resetInimigo    (resetInimigo),
        .pausa           (pausa),
        .inim_x          (inim_x),
        .inim_y          (inim_y),
        .inim_larg       (inim_larg),
        .inim_alt        (inim_alt),
        .tiro_valido     (tiro_valido),
        .tiro_x          (tiro_x),
        .tiro_y          (tiro_y),
        .tiro_consumido  (tiro_consumido),
        .acerto          (acerto),
        .vidas           (vidas),
        .inimigo_visivel (inimigo_visivel),
        .destruido       (destruido),
        .pontos          (pontos)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, compared=%0d required=finish", n_cmp);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0] bx, by, bl, ba;
        logic [9:0] sx, sy;
        logic       ack;
        string      nome;
    } vetor_t;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        resetInimigo = 1'b1;
        tick();
        resetInimigo = 1'b0;
    endtask

    task automatic caixa_padrao();
        inim_x = 10'd300; inim_y = 10'd300; inim_larg = 10'd11; inim_alt = 10'd8;
        tiro_x = 10'd305; tiro_y = 10'd302;
    endtask

    // Shot at edge N, ack expected right after edge N+1, gone after N+2.
    task automatic hit_and_check(input string nome, input logic [2:0] exp_vidas, input logic [15:0] exp_pts);
        tiro_valido = 1'b1;
        tick();
        check({nome, "_ack_early"}, tiro_consumido, 1'b0);
        tick();
        check({nome, "_ack"}, tiro_consumido, 1'b1);
        check({nome, "_acerto"}, acerto, 1'b1);
        check({nome, "_vidas"}, vidas, exp_vidas);
        check({nome, "_pontos"}, pontos, exp_pts);
        tiro_valido = 1'b0;
        tick();
        check({nome, "_ack_pulse"}, tiro_consumido, 1'b0);
    endtask

    // Visibility k edges after entering invulnerability (T_INV=20, P_DIV=4).
    function automatic logic vis_exp(input int k);
        if (k >= T_INV) return 1'b1;
        return ((k / P_DIV) % 2) == 0;
    endfunction

    vetor_t tab[$];
    int acks;

    initial begin
        resetInimigo = 1'b1; pausa = 1'b0; tiro_valido = 1'b0;
        caixa_padrao();
        #3;
        check("rst_vidas", vidas, 3'd3);
        check("rst_visivel", inimigo_visivel, 1'b1);
        check("rst_destruido", destruido, 1'b0);
        check("rst_ack", tiro_consumido, 1'b0);
        check("rst_acerto", acerto, 1'b0);
        check("rst_pontos", pontos, 16'd0);
        @(negedge CLOCK_50);
        resetInimigo = 1'b0;

        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd305, 10'd302, 1'b1, "centro"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd311, 10'd302, 1'b0, "dir_excl"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd310, 10'd302, 1'b1, "dir_incl"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd298, 10'd302, 1'b0, "esq_excl"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd299, 10'd302, 1'b1, "esq_incl"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd305, 10'd308, 1'b0, "baixo_excl"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd305, 10'd307, 1'b1, "baixo_incl"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd305, 10'd294, 1'b0, "cima_excl"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd8, 10'd305, 10'd295, 1'b1, "cima_incl"});
        tab.push_back('{10'd300, 10'd300, 10'd0,  10'd8, 10'd299, 10'd302, 1'b0, "larg_zero"});
        tab.push_back('{10'd300, 10'd300, 10'd11, 10'd0, 10'd305, 10'd299, 1'b0, "alt_zero"});
        tab.push_back('{10'd1015, 10'd300, 10'd10, 10'd8, 10'd1022, 10'd302, 1'b1, "sem_wrap"});

        foreach (tab[i]) begin
            do_reset();
            inim_x = tab[i].bx; inim_y = tab[i].by; inim_larg = tab[i].bl; inim_alt = tab[i].ba;
            tiro_x = tab[i].sx; tiro_y = tab[i].sy;
            tiro_valido = 1'b1;
            tick();
            tick();
            check({"tab_ack_", tab[i].nome}, tiro_consumido, tab[i].ack);
            check({"tab_acerto_", tab[i].nome}, acerto, tab[i].ack);
            tiro_valido = 1'b0;
            tick();
            check({"tab_vidas_", tab[i].nome}, vidas, tab[i].ack ? 3'd2 : 3'd3);
        end

        // Shot held five cycles: single ack, then blink through invulnerability.
        do_reset();
        caixa_padrao();
        tiro_valido = 1'b1;
        acks = 0;
        tick();
        check("held_latency", tiro_consumido, 1'b0);
        tick();
        check("held_ack", tiro_consumido, 1'b1);
        check("held_acerto", acerto, 1'b1);
        check("held_vidas", vidas, 3'd2);
        check("held_pontos", pontos, 16'd10);
        acks += int'(tiro_consumido);
        for (int j = 0; j < 3; j++) begin
            tick();
            acks += int'(tiro_consumido);
        end
        tiro_valido = 1'b0;
        check("held_acks", acks, 1);
        check("held_vidas_after", vidas, 3'd2);
        for (int k = 4; k <= T_INV; k++) begin
            tick();
            check($sformatf("blink_k%0d", k), inimigo_visivel, vis_exp(k));
        end

        // Second and third hits; the third one is fatal.
        hit_and_check("hit2", 3'd1, 16'd20);
        repeat (T_INV - 1) tick();
        check("invuln_end_vis", inimigo_visivel, 1'b1);
        hit_and_check("hit3", 3'd0, 16'd30);
        check("dead_destruido", destruido, 1'b1);
        check("dead_visivel", inimigo_visivel, 1'b0);
        tiro_valido = 1'b1;
        acks = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            acks += int'(tiro_consumido);
        end
        tiro_valido = 1'b0;
        check("dead_no_ack", acks, 0);
        check("dead_vidas", vidas, 3'd0);
        check("dead_pontos", pontos, 16'd30);
        check("dead_hold", destruido, 1'b1);

        // Pause during invulnerability freezes timers and blocks acks.
        do_reset();
        caixa_padrao();
        hit_and_check("pausa_hit", 3'd2, 16'd10);
        tick();
        pausa = 1'b1;
        tiro_valido = 1'b1;
        acks = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            acks += int'(tiro_consumido);
        end
        check("pausa_no_ack", acks, 0);
        check("pausa_vis_hold", inimigo_visivel, 1'b1);
        check("pausa_vidas", vidas, 3'd2);
        pausa = 1'b0;
        tiro_valido = 1'b0;
        for (int u = 1; u <= T_INV - 2; u++) begin
            tick();
            check($sformatf("pausa_blink_u%0d", u), inimigo_visivel, vis_exp(2 + u));
        end
        hit_and_check("pausa_resume", 3'd1, 16'd20);

        // Pending stage-1 result discarded by pause.
        do_reset();
        caixa_padrao();
        tiro_valido = 1'b1;
        tick();
        pausa = 1'b1;
        tiro_valido = 1'b0;
        tick();
        check("pend_pausa_ack", tiro_consumido, 1'b0);
        pausa = 1'b0;
        tick();
        check("pend_pausa_ack2", tiro_consumido, 1'b0);
        check("pend_pausa_vidas", vidas, 3'd3);

        // Shot withdrawn before the ack.
        do_reset();
        tiro_valido = 1'b1;
        tick();
        tiro_valido = 1'b0;
        tick();
        check("withdraw_ack", tiro_consumido, 1'b0);
        tick();
        check("withdraw_vidas", vidas, 3'd3);

        // Reset mid-invulnerability.
        do_reset();
        hit_and_check("rst_inv_hit", 3'd2, 16'd10);
        repeat (5) tick();
        resetInimigo = 1'b1;
        #1;
        check("rst_inv_vidas", vidas, 3'd3);
        check("rst_inv_vis", inimigo_visivel, 1'b1);
        check("rst_inv_pontos", pontos, 16'd0);
        @(negedge CLOCK_50);
        resetInimigo = 1'b0;
        hit_and_check("rst_inv_ativo", 3'd2, 16'd10);

        // Reset mid-pipeline: the captured overlap must not produce an ack.
        do_reset();
        tiro_valido = 1'b1;
        tick();
        resetInimigo = 1'b1;
        tiro_valido = 1'b0;
        tick();
        resetInimigo = 1'b0;
        check("rst_pipe_ack", tiro_consumido, 1'b0);
        tick();
        check("rst_pipe_ack2", tiro_consumido, 1'b0);
        check("rst_pipe_acerto", acerto, 1'b0);
        check("rst_pipe_vidas", vidas, 3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
